pipeline_ctrl: RTL and testbench

Pipeline stall/flush controller for the 5-stage CPU. It sits directly upstream of the EX-stage forwarding logic. It decides, each cycle, which pipeline latches advance, hold or load a bubble, so the ID/EX latch only presents forwardable instructions. It resolves instruction/data memory waits, load-use hazards (the one case forwarding cannot cover), taken branches/jumps and halt. It also keeps a saturating stall-cycle counter.

---
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core.
// Decides each cycle which pipeline latches advance, hold or take a bubble so that
// ID/EX only ever holds instructions the EX forwarding network can serve. Also keeps a
// saturating count of cycles in which the PC was held.
module pipeline_ctrl #(
   parameter int unsigned CPUID = 0,
   parameter int unsigned CNTW  = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [31:0]     instr_1,
   input  logic            MemToReg_2,
   input  logic [4:0]      wsel_2,
   input  logic            dREN_3,
   input  logic            dWEN_3,
   input  logic            ihit,
   input  logic            dhit,
   input  logic            pcsrc_taken,
   input  logic            halt_3,
   output logic            pc_en,
   output logic            ifid_en,
   output logic            idex_en,
   output logic            exmem_en,
   output logic            memwb_en,
   output logic            ifid_flush,
   output logic            idex_flush,
   output logic            halted,
   output logic [CNTW-1:0] stall_cnt
);

   typedef enum logic [1:0] {StRun, StDwait, StHalted} state_e;

   state_e          state_q;
   logic            halted_q;
   logic [CNTW-1:0] stall_cnt_q;

   logic [5:0] opcode;
   logic [4:0] rs, rt;
   logic       rt_read;
   logic       load_use;
   logic       dpend;

   // CPUID is informational; fold it and the unused instruction bits into a sink.
   logic unused_bits;
   assign unused_bits = ^{32'(CPUID), instr_1[15:0]};

   assign opcode = instr_1[31:26];
   assign rs     = instr_1[25:21];
   assign rt     = instr_1[20:16];

   // Load-use hazard detection: rt only counts for formats that read it as a source.
   always_comb begin
      rt_read  = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h05) ||
                 (opcode == 6'h2B);
      load_use = MemToReg_2 && (wsel_2 != 5'd0) &&
                 ((rs == wsel_2) || (rt_read && (rt == wsel_2)));
      dpend    = (dREN_3 || dWEN_3) && !dhit;
   end

   // Combinational latch control, evaluated in strict priority order.
   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (RST) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (state_q == StHalted || dpend) begin
         // Freeze: nothing moves, so held hazards are re-evaluated on release.
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      end else if (halt_3) begin
         // Let HALT retire through MEM/WB, hold everything behind it.
         {pc_en, ifid_en, idex_en, exmem_en} = '0;
      end else if (pcsrc_taken) begin
         // Redirect now; squash the two wrong-path slots (also covers load-use).
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         // Hold IF/ID and PC, inject one bubble into ID/EX.
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (!ihit) begin
         // Fetch not done: hold PC, feed a NOP into decode, drain the rest.
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   // State, sticky halt flag and saturating stall counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StRun;
         halted_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q != StHalted) begin
            if (dpend) begin
               state_q <= StDwait;
            end else if (halt_3) begin
               state_q  <= StHalted;
               halted_q <= 1'b1;
            end else begin
               state_q <= StRun;
            end
            if (!pc_en && (stall_cnt_q != '1)) begin
               stall_cnt_q <= stall_cnt_q + CNTW'(1);
            end
         end
      end
   end

   assign halted    = halted_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed literal checks followed by random stimulus,
// with every cycle compared against a behavioural model of the control rules.
module tb_pipeline_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] instr_1;
   logic        MemToReg_2;
   logic [4:0]  wsel_2;
   logic        dREN_3, dWEN_3, ihit, dhit, pcsrc_taken, halt_3;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
   logic [15:0] stall_cnt;
   logic [3:0]  sat_cnt;
   logic        unused_s0, unused_s1, unused_s2, unused_s3, unused_s4, unused_s5, unused_s6;
   logic        unused_s7;

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;

   // Model state: only "halted" and the raw number of held-PC cycles matter.
   logic m_halted = 1'b0;
   int   m_total  = 0;

   always #5 CLK = ~CLK;

   pipeline_ctrl #(.CPUID(0), .CNTW(16)) u_dut (
      .CLK(CLK), .RST(RST), .instr_1(instr_1), .MemToReg_2(MemToReg_2), .wsel_2(wsel_2),
      .dREN_3(dREN_3), .dWEN_3(dWEN_3), .ihit(ihit), .dhit(dhit), .pcsrc_taken(pcsrc_taken),
      .halt_3(halt_3), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .halted(halted), .stall_cnt(stall_cnt)
   );

   pipeline_ctrl #(.CPUID(1), .CNTW(4)) u_sat (
      .CLK(CLK), .RST(RST), .instr_1(instr_1), .MemToReg_2(MemToReg_2), .wsel_2(wsel_2),
      .dREN_3(dREN_3), .dWEN_3(dWEN_3), .ihit(ihit), .dhit(dhit), .pcsrc_taken(pcsrc_taken),
      .halt_3(halt_3), .pc_en(unused_s0), .ifid_en(unused_s1), .idex_en(unused_s2),
      .exmem_en(unused_s3), .memwb_en(unused_s4), .ifid_flush(unused_s5),
      .idex_flush(unused_s6), .halted(unused_s7), .stall_cnt(sat_cnt)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   // Source registers an instruction reads, straight from the encoding rules.
   function automatic logic model_load_use();
      logic [5:0] rt_ops [4];
      logic       reads_rt;
      rt_ops = '{6'h00, 6'h04, 6'h05, 6'h2B};
      reads_rt = 1'b0;
      foreach (rt_ops[i]) if (instr_1[31:26] == rt_ops[i]) reads_rt = 1'b1;
      if (!MemToReg_2 || wsel_2 == 5'd0) return 1'b0;
      return (instr_1[25:21] == wsel_2) || (reads_rt && instr_1[20:16] == wsel_2);
   endfunction

   // Expected {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}.
   function automatic logic [6:0] model_ctrl();
      if (RST)                               return 7'b00000_11;
      if (m_halted)                          return 7'b00000_00;
      if ((dREN_3 || dWEN_3) && !dhit)       return 7'b00000_00;
      if (halt_3)                            return 7'b00001_00;
      if (pcsrc_taken)                       return 7'b11111_11;
      if (model_load_use())                  return 7'b00111_01;
      if (!ihit)                             return 7'b01111_10;
      return 7'b11111_00;
   endfunction

   always @(posedge CLK) begin
      logic [6:0] c;
      c = model_ctrl();
      if (RST) begin
         m_halted <= 1'b0;
         m_total  <= 0;
      end else if (!m_halted) begin
         if (!c[6]) m_total <= m_total + 1;
         if (!((dREN_3 || dWEN_3) && !dhit) && halt_3) m_halted <= 1'b1;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("ctrl", {25'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
                        idex_flush}, {25'd0, model_ctrl()});
         check("halted", {31'd0, halted}, {31'd0, m_halted});
         check("cnt16", {16'd0, stall_cnt}, (m_total > 65535) ? 32'd65535 : 32'(m_total));
         check("cnt4", {28'd0, sat_cnt}, (m_total > 15) ? 32'd15 : 32'(m_total));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      instr_1 = 32'd0; MemToReg_2 = 1'b0; wsel_2 = 5'd0; dREN_3 = 1'b0; dWEN_3 = 1'b0;
      ihit = 1'b1; dhit = 1'b0; pcsrc_taken = 1'b0; halt_3 = 1'b0;
   endtask

   task automatic chk_ctrl(input string nm, input logic [6:0] exp);
      check(nm, {25'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush},
            {25'd0, exp});
   endtask

   localparam logic [31:0] AddRt8  = {6'h00, 5'd9, 5'd8, 5'd10, 5'd0, 6'h20};
   localparam logic [31:0] AddRt0  = {6'h00, 5'd9, 5'd0, 5'd10, 5'd0, 6'h20};
   localparam logic [31:0] SwRt8   = {6'h2B, 5'd9, 5'd8, 16'h0004};
   localparam logic [31:0] BneRt8  = {6'h05, 5'd9, 5'd8, 16'h0010};
   localparam logic [31:0] AddiRt8 = {6'h08, 5'd9, 5'd8, 16'h0001};

   initial begin
      logic [5:0] ops [6];
      ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h23};
      idle();
      RST = 1'b1;
      tick();
      chk_en = 1'b1;
      @(negedge CLK);
      chk_ctrl("rst_ctrl", 7'b00000_11);
      check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
      tick();
      RST = 1'b0;
      @(negedge CLK);
      chk_ctrl("run_ctrl", 7'b11111_00);

      // Load-use through rt of an R-type: one bubble.
      tick(); MemToReg_2 = 1'b1; wsel_2 = 5'd8; instr_1 = AddRt8;
      @(negedge CLK);
      chk_ctrl("lu_add", 7'b00111_01);
      tick(); idle();
      @(negedge CLK);
      check("lu_cnt1", {16'd0, stall_cnt}, 32'd1);
      tick(); MemToReg_2 = 1'b1; wsel_2 = 5'd0; instr_1 = AddRt0;
      @(negedge CLK);
      check("lu_r0", {31'd0, pc_en}, 32'd1);
      tick(); wsel_2 = 5'd8; instr_1 = SwRt8;
      @(negedge CLK);
      check("lu_sw", {31'd0, pc_en}, 32'd0);
      tick(); instr_1 = BneRt8;
      @(negedge CLK);
      check("lu_bne", {31'd0, pc_en}, 32'd0);
      tick(); instr_1 = AddiRt8;
      @(negedge CLK);
      check("lu_addi", {31'd0, pc_en}, 32'd1);
      tick(); idle();
      @(negedge CLK);
      check("lu_cnt3", {16'd0, stall_cnt}, 32'd3);

      // Data wait: three frozen cycles, release on dhit.
      for (int i = 0; i < 3; i++) begin
         tick(); dREN_3 = 1'b1; dhit = 1'b0;
         @(negedge CLK);
         chk_ctrl("dwait", 7'b00000_00);
      end
      tick(); dhit = 1'b1;
      @(negedge CLK);
      chk_ctrl("dwait_rel", 7'b11111_00);
      tick(); idle();
      @(negedge CLK);
      check("dwait_cnt", {16'd0, stall_cnt}, 32'd6);

      // Branch wins over load-use.
      tick(); pcsrc_taken = 1'b1; MemToReg_2 = 1'b1; wsel_2 = 5'd8; instr_1 = AddRt8;
      @(negedge CLK);
      chk_ctrl("br_lu", 7'b11111_11);
      tick(); idle();
      @(negedge CLK);
      check("br_cnt", {16'd0, stall_cnt}, 32'd6);

      // Halt: MEM/WB drains once, then everything stays frozen.
      tick(); halt_3 = 1'b1;
      @(negedge CLK);
      chk_ctrl("halt_drain", 7'b00001_00);
      tick(); idle();
      @(negedge CLK);
      check("halt_flag", {31'd0, halted}, 32'd1);
      chk_ctrl("halt_frz", 7'b00000_00);
      tick(); ihit = 1'b0; tick(); tick();
      @(negedge CLK);
      check("halt_cnt", {16'd0, stall_cnt}, 32'd7);
      tick(); RST = 1'b1;
      tick(); RST = 1'b0; idle();
      @(negedge CLK);
      check("halt_clr", {31'd0, halted}, 32'd0);
      check("halt_cnt0", {16'd0, stall_cnt}, 32'd0);

      // Saturation of the 4-bit counter.
      tick(); ihit = 1'b0;
      repeat (20) tick();
      ihit = 1'b1;
      @(negedge CLK);
      check("sat4", {28'd0, sat_cnt}, 32'd15);
      check("sat16", {16'd0, stall_cnt}, 32'd20);

      // Random phase against the model.
      for (int n = 0; n < 3000; n++) begin
         tick();
         RST         = ($urandom_range(0, 99) < (m_halted ? 25 : 1));
         instr_1     = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 16'($urandom)};
         MemToReg_2  = ($urandom_range(0, 99) < 30);
         wsel_2      = 5'($urandom_range(0, 3));
         dREN_3      = ($urandom_range(0, 99) < 20);
         dWEN_3      = ($urandom_range(0, 99) < 15);
         ihit        = ($urandom_range(0, 99) < 80);
         dhit        = ($urandom_range(0, 99) < 50);
         pcsrc_taken = ($urandom_range(0, 99) < 15);
         halt_3      = ($urandom_range(0, 99) < 3);
      end
      tick(); idle(); RST = 1'b0;
      @(negedge CLK);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
